// File: rtl/alu_mc_unit_if.sv
// Request/result bus of the multi-cycle ALU.
// master drives requests and consumes results; slave is the ALU itself.
interface alu_mc_unit_if #(
    parameter int N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   operand1;
    logic [N-1:0]   operand2;
    logic [2:0]     operation;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] alu_out;
    logic           busy;

    modport master (
        output in_valid, operand1, operand2, operation, out_ready,
        input  in_ready, out_valid, alu_out, busy
    );

    modport slave (
        input  in_valid, operand1, operand2, operation, out_ready,
        output in_ready, out_valid, alu_out, busy
    );
endinterface

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU: single-cycle add/and/sub/or/xor/slt, N-cycle shift-add
// multiply and N-cycle restoring divide, with a valid/ready request side
// and a valid/ready result side. One operation in flight at a time.
// The interface instance must be built with the same N as this module.
module alu_mc_unit #(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_mc_unit_if.slave  bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MULT = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_SLT  = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state_reg;
    logic [W-1:0]   alu_out_reg;
    logic [W-1:0]   acc_reg;       // running product
    logic [W-1:0]   mcand_reg;     // multiplicand, shifted left each iteration
    logic [N-1:0]   mplier_reg;    // multiplier, shifted right each iteration
    logic [N-1:0]   divisor_reg;
    logic [N-1:0]   rem_reg;       // partial remainder
    logic [N-1:0]   quo_reg;       // dividend bits shift out, quotient bits shift in
    logic [CW-1:0]  cnt_reg;

    logic [N-1:0]   and_bits;
    logic [N-1:0]   or_bits;
    logic [N-1:0]   xor_bits;
    logic [N:0]     add_sum;
    logic [W-1:0]   quick_result;
    logic [W-1:0]   mul_sum;
    logic [N:0]     div_trial;
    logic           div_ge;
    logic [N-1:0]   div_rem_next;
    logic [N-1:0]   quo_next;

    // Per-bit logic operations on the live request operands
    for (genvar gi = 0; gi < N; gi++) begin : g_bitwise
        assign and_bits[gi] = bus.operand1[gi] & bus.operand2[gi];
        assign or_bits[gi]  = bus.operand1[gi] | bus.operand2[gi];
        assign xor_bits[gi] = bus.operand1[gi] ^ bus.operand2[gi];
    end

    assign add_sum = {1'b0, bus.operand1} + {1'b0, bus.operand2};

    // Result of the single-cycle operations, loaded on the accept edge
    always_comb begin
        quick_result = '0;
        case (bus.operation)
            OP_ADD:  quick_result = W'(add_sum);
            OP_AND:  quick_result = W'(and_bits);
            OP_SUB:  quick_result = W'(bus.operand1) - W'(bus.operand2);
            OP_OR:   quick_result = W'(or_bits);
            OP_XOR:  quick_result = W'(xor_bits);
            OP_SLT:  quick_result = W'(bus.operand1 < bus.operand2);
            default: quick_result = '0;
        endcase
    end

    // One shift-add step and one restoring-division step.
    // A zero divisor always passes the trial subtract, which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    always_comb begin
        mul_sum      = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        div_trial    = {rem_reg, quo_reg[N-1]};
        div_ge       = (div_trial >= {1'b0, divisor_reg});
        div_rem_next = div_ge ? N'(div_trial - {1'b0, divisor_reg}) : div_trial[N-1:0];
        quo_next     = {quo_reg[N-2:0], div_ge};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            alu_out_reg <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (bus.in_valid) begin
                        case (bus.operation)
                            OP_MULT: begin
                                acc_reg    <= '0;
                                mcand_reg  <= W'(bus.operand1);
                                mplier_reg <= bus.operand2;
                                state_reg  <= MUL;
                            end
                            OP_DIV: begin
                                rem_reg     <= '0;
                                quo_reg     <= bus.operand1;
                                divisor_reg <= bus.operand2;
                                state_reg   <= DIV;
                            end
                            default: begin
                                alu_out_reg <= quick_result;
                                state_reg   <= DONE;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_reg    <= mul_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    if (cnt_reg == LAST) begin
                        alu_out_reg <= mul_sum;
                        cnt_reg     <= '0;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DIV: begin
                    rem_reg <= div_rem_next;
                    quo_reg <= quo_next;
                    if (cnt_reg == LAST) begin
                        alu_out_reg <= {div_rem_next, quo_next};
                        cnt_reg     <= '0;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    cnt_reg <= '0;
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.alu_out   = alu_out_reg;
endmodule
